group_arbiter_level_1: RTL

Upper-level round-robin arbiter that closes the loop with the level-0 pixel group stage. It consumes the per-group request matrix and the group-release pulse from level 0. It drives back the one-hot group enable that selects which level-0 group may arbitrate its pixels. It also supplies the granted group's row/column address, an activity flag, a watchdog timeout flag and a grant counter to the event readout path.

---
 rtl/group_arbiter_level_1.sv | 106 ++++++++++
 1 files changed

// File: rtl/group_arbiter_level_1.sv
// Level-1 round-robin arbiter: grants one level-0 pixel group at a time, holds the
// enable until the group releases or the watchdog expires, then rotates priority.
module group_arbiter_level_1 #(
  parameter int Lvl_ROWS = 4,
  parameter int Lvl_COLS = 4,
  parameter int ADD_W    = 2,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  req_i,
  input  logic                               grp_release_i,
  output logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  enable_o,
  output logic [ADD_W-1:0]                   x_add_o,
  output logic [ADD_W-1:0]                   y_add_o,
  output logic                               active_o,
  output logic                               timeout_o,
  output logic [CNT_W-1:0]                   grant_cnt_o
);

  localparam int N     = Lvl_ROWS * Lvl_COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      req_flat;
  logic [IDX_W-1:0]  ptr_q, sel_q, pick, cand, sel_inc;
  logic [WD_W-1:0]   wd_q;
  logic              any_req, wd_exp, grant_start, grant_end;

  assign req_flat = req_i;

  // First requester at or after ptr, wrapping at N (N need not be a power of two).
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    cand    = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!any_req && req_flat[cand]) begin
        pick    = cand;
        any_req = 1'b1;
      end
      cand = (cand == IDX_W'(N-1)) ? '0 : cand + 1'b1;
    end
  end

  assign sel_inc     = (sel_q == IDX_W'(N-1)) ? '0 : sel_q + 1'b1;
  assign wd_exp      = (wd_q == WD_W'(TIMEOUT-1));
  assign grant_start = (state_q == IDLE) && any_req;
  assign grant_end   = (state_q == GRANT) && (grp_release_i || wd_exp);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)       state_d = GRANT;
      GRANT:   if (grant_end)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Registered outputs and datapath; no input reaches an output combinationally.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      enable_o    <= '0;
      x_add_o     <= '0;
      y_add_o     <= '0;
      active_o    <= 1'b0;
      timeout_o   <= 1'b0;
      grant_cnt_o <= '0;
      ptr_q       <= '0;
      sel_q       <= '0;
      wd_q        <= '0;
    end else begin
      timeout_o <= 1'b0;
      if (grant_start) begin
        sel_q       <= pick;
        enable_o    <= ONE << pick;
        x_add_o     <= ADD_W'(pick / IDX_W'(Lvl_COLS));
        y_add_o     <= ADD_W'(pick % IDX_W'(Lvl_COLS));
        active_o    <= 1'b1;
        wd_q        <= '0;
        grant_cnt_o <= grant_cnt_o + 1'b1;
      end else if (grant_end) begin
        enable_o  <= '0;
        x_add_o   <= '0;
        y_add_o   <= '0;
        active_o  <= 1'b0;
        ptr_q     <= sel_inc;
        // A release coinciding with expiry is a normal release.
        timeout_o <= !grp_release_i;
      end else if (state_q == GRANT) begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end

endmodule
